// File: rtl/branch_pkg.sv
// Branch condition op codes and decode helper shared by
// the branch resolve unit and its condition evaluator.
package branch_pkg;

    localparam logic [3:0] OP_LT = 4'b0100;
    localparam logic [3:0] OP_GT = 4'b0101;
    localparam logic [3:0] OP_EQ = 4'b0110;
    localparam logic [3:0] OP_NE = 4'b0111;
    localparam logic [3:0] OP_LE = 4'b1000;
    localparam logic [3:0] OP_GE = 4'b1001;

    function automatic logic is_cmp_op(input logic [3:0] op);
        return (op inside {OP_LT, OP_GT, OP_EQ, OP_NE, OP_LE, OP_GE});
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Instruction bus into the branch resolve unit and the
// registered EX/MEM result coming back out.
interface branch_resolve_unit_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  in_valid;
    logic                  branch_en;
    logic                  signed_mode;
    logic [3:0]            op_code;
    logic [WIDTH-1:0]      in1;
    logic [WIDTH-1:0]      in2;
    logic [ADDR_WIDTH-1:0] target_in;
    logic                  out_valid;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target_out;

    modport master (
        output in_valid, branch_en, signed_mode, op_code,
        output in1, in2, target_in,
        input  out_valid, taken, target_out
    );

    modport slave (
        input  in_valid, branch_en, signed_mode, op_code,
        input  in1, in2, target_in,
        output out_valid, taken, target_out
    );
endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational branch relation on two operands,
// signed or unsigned; non-compare op codes yield 0.
module cond_eval
    import branch_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       op_code,
    input  logic             signed_mode,
    output logic             cond_now
);
    logic lt;
    logic eq;

    always_comb begin
        eq = (in1 == in2);
        lt = signed_mode ? ($signed(in1) < $signed(in2)) : (in1 < in2);
        case (op_code)
            OP_LT:   cond_now = lt;
            OP_GT:   cond_now = ~lt & ~eq;
            OP_EQ:   cond_now = eq;
            OP_NE:   cond_now = ~eq;
            OP_LE:   cond_now = lt | eq;
            OP_GE:   cond_now = ~lt;
            default: cond_now = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: registers taken/target into EX/MEM,
// with sticky condition flag and saturating taken counter.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 count_clear,
    branch_resolve_unit_if.slave bus,
    output logic                 cond_flag,
    output logic [CNT_WIDTH-1:0] taken_count
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                  cond_now;
    logic                  fire;
    logic                  take;
    logic                  out_valid_q, out_valid_d;
    logic                  taken_q, taken_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic                  cond_q, cond_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
        .in1         (bus.in1),
        .in2         (bus.in2),
        .op_code     (bus.op_code),
        .signed_mode (bus.signed_mode),
        .cond_now    (cond_now)
    );

    assign fire = bus.in_valid & ~stall & is_cmp_op(bus.op_code);
    assign take = bus.in_valid & bus.branch_en & cond_now;

    always_comb begin
        out_valid_d = out_valid_q;
        taken_d     = taken_q;
        target_d    = target_q;
        cond_d      = fire ? cond_now : cond_q;
        cnt_d       = cnt_q;
        // flush kills the slot but keeps the last target visible
        if (flush) begin
            out_valid_d = 1'b0;
            taken_d     = 1'b0;
        end else if (!stall) begin
            out_valid_d = bus.in_valid;
            taken_d     = take;
            if (bus.in_valid) target_d = bus.target_in;
        end
        if (count_clear) begin
            cnt_d = '0;
        end else if (!flush && !stall && take && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
            cond_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            taken_q     <= taken_d;
            target_q    <= target_d;
            cond_q      <= cond_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.taken      = taken_q;
    assign bus.target_out = target_q;
    assign cond_flag      = cond_q;
    assign taken_count    = cnt_q;
endmodule
